// File: rtl/dot_pe_pkg.sv
// Shared types and saturation limits for the accumulating dot-product PE.
package dot_pe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_t;

    // Where a saturation event originated; any set bit marks the vector as saturated.
    typedef struct packed {
        logic prod;
        logic tree;
        logic acc;
    } sat_evt_t;

    function automatic int sat_max(input int dw);
        return (1 << (dw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dw);
        return -(1 << (dw - 1));
    endfunction

endpackage

// File: rtl/dot_pe_acc_if.sv
// Beat, weight and result signals of the accumulating dot-product PE.
interface dot_pe_acc_if #(
    parameter int LANES = 8,
    parameter int DW    = 8
);
    logic [LANES*DW-1:0] i_data;
    logic                i_valid;
    logic                i_last;
    logic [LANES*DW-1:0] i_weight;
    logic                i_w_load;
    logic [DW-1:0]       o_data;
    logic                o_valid;
    logic                o_sat;

    modport master (
        output i_data, i_valid, i_last, i_weight, i_w_load,
        input  o_data, o_valid, o_sat
    );

    modport slave (
        input  i_data, i_valid, i_last, i_weight, i_w_load,
        output o_data, o_valid, o_sat
    );
endinterface

// File: rtl/dot_pe_sat_add.sv
// DW-bit signed adder with symmetric saturation (+max / -max) and an overflow flag.
module dot_pe_sat_add #(
    parameter int DW = 8
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] sum,
    output logic                 ov
);
    import dot_pe_pkg::*;

    localparam logic signed [DW-1:0] SMAX = DW'(sat_max(DW));
    localparam logic signed [DW-1:0] SNEG = -SMAX;

    logic signed [DW-1:0] raw;

    always_comb begin
        raw = a + b;
        ov  = (a[DW-1] == b[DW-1]) && (raw[DW-1] != a[DW-1]);
        if (!ov) begin
            sum = raw;
        end else if (a[DW-1]) begin
            sum = SNEG;
        end else begin
            sum = SMAX;
        end
    end
endmodule

// File: rtl/dot_pe_acc.sv
// Accumulating LANES-wide saturating dot-product PE: product reg, registered adder tree, accumulator.
// Build option DOT_PE_ACC_ROUND_EN: round half up before the product shift (default truncates).
//
//   state | meaning
//   IDLE  | next valid beat at the accumulator starts a new vector
//   ACC   | partial vector held in acc_q, waiting for further beats
module dot_pe_acc #(
    parameter int LANES = 8,
    parameter int DW    = 8,
    parameter int FRAC  = 5
) (
    input logic         clk,
    input logic         rst,
    dot_pe_acc_if.slave bus
);
    import dot_pe_pkg::*;

    localparam int LVLS  = $clog2(LANES);
    localparam int NODES = 2 * LANES - 1;
    localparam logic signed [DW-1:0] SMAX = DW'(sat_max(DW));
    localparam logic signed [DW-1:0] SMIN = DW'(sat_min(DW));
`ifdef DOT_PE_ACC_ROUND_EN
    localparam logic signed [2*DW-1:0] RND_C = (2*DW)'(1 << (FRAC - 1));
`endif

    logic [LANES*DW-1:0]  w_q;
    logic signed [DW-1:0] prod_d [LANES];
    logic [LANES-1:0]     prod_ov;

    // Heap-ordered tree: node i sums nodes 2i+1 and 2i+2; lane k sits at leaf LANES-1+k.
    logic signed [DW-1:0] node_q [NODES];
    logic signed [DW-1:0] sum_c  [LANES-1];
    logic [LANES-2:0]     ov_c;
    logic [LVLS-1:0]      lvl_ov;

    // Stage bookkeeping indexed by tree depth; index LVLS is the product register.
    logic [LVLS:0] vld_q;
    logic [LVLS:0] last_q;
    sat_evt_t      evt_q [LVLS+1];

    acc_state_t           state_q, state_d;
    logic signed [DW-1:0] acc_q, acc_d;
    logic                 sticky_q, sticky_d;
    logic signed [DW-1:0] acc_sum;
    logic                 acc_ov;
    logic signed [DW-1:0] beat_sum;
    sat_evt_t             beat_ev;
    logic                 beat_sat;
    logic [DW-1:0]        o_data_q, o_data_d;
    logic                 o_valid_q, o_valid_d;
    logic                 o_sat_q, o_sat_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
        end else if (bus.i_w_load) begin
            w_q <= bus.i_weight;
        end
    end

    // A beat in the same cycle as a weight load still sees w_q, i.e. the old weights.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DW-1:0]   d_l;
        logic signed [DW-1:0]   w_l;
        logic signed [2*DW-1:0] full;
        logic signed [2*DW-1:0] shifted;

        assign d_l = bus.i_data[k*DW +: DW];
        assign w_l = w_q[k*DW +: DW];
`ifdef DOT_PE_ACC_ROUND_EN
        assign full = d_l * w_l + RND_C;
`else
        assign full = d_l * w_l;
`endif
        assign shifted = full >>> FRAC;
        // The field fits when every bit above it matches its sign bit.
        assign prod_ov[k] = !((&shifted[2*DW-1:DW-1]) || (~|shifted[2*DW-1:DW-1]));
        assign prod_d[k]  = prod_ov[k] ? (shifted[2*DW-1] ? SMIN : SMAX) : shifted[DW-1:0];
    end

    for (genvar i = 0; i < LANES - 1; i++) begin : g_node
        dot_pe_sat_add #(.DW(DW)) u_add (
            .a   (node_q[2*i+1]),
            .b   (node_q[2*i+2]),
            .sum (sum_c[i]),
            .ov  (ov_c[i])
        );
    end

    for (genvar d = 0; d < LVLS; d++) begin : g_lvl
        assign lvl_ov[d] = |ov_c[(2**(d+1))-2 : (2**d)-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < NODES; n++) begin
                node_q[n] <= '0;
            end
            for (int d = 0; d <= LVLS; d++) begin
                evt_q[d] <= '0;
            end
            vld_q  <= '0;
            last_q <= '0;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                node_q[LANES-1+k] <= prod_d[k];
            end
            for (int n = 0; n < LANES - 1; n++) begin
                node_q[n] <= sum_c[n];
            end
            vld_q[LVLS]  <= bus.i_valid;
            last_q[LVLS] <= bus.i_valid & bus.i_last;
            evt_q[LVLS]  <= '{prod: bus.i_valid & (|prod_ov), tree: 1'b0, acc: 1'b0};
            for (int d = 0; d < LVLS; d++) begin
                vld_q[d]  <= vld_q[d+1];
                last_q[d] <= last_q[d+1];
                evt_q[d]  <= '{prod: evt_q[d+1].prod,
                               tree: evt_q[d+1].tree | (vld_q[d+1] & lvl_ov[d]),
                               acc:  1'b0};
            end
        end
    end

    dot_pe_sat_add #(.DW(DW)) u_acc (
        .a   (acc_q),
        .b   (node_q[0]),
        .sum (acc_sum),
        .ov  (acc_ov)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            sticky_q  <= 1'b0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_sat_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sticky_q  <= sticky_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_sat_q   <= o_sat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sticky_d  = sticky_q;
        o_data_d  = o_data_q;
        o_valid_d = 1'b0;
        o_sat_d   = o_sat_q;
        beat_ev   = evt_q[0];
        beat_sum  = node_q[0];

        case (state_q)
            IDLE: begin
                beat_sum    = node_q[0];
                beat_ev.acc = 1'b0;
            end
            ACC: begin
                beat_sum    = acc_sum;
                beat_ev.acc = acc_ov;
            end
            default: begin
                beat_sum    = node_q[0];
                beat_ev.acc = 1'b0;
            end
        endcase
        beat_sat = sticky_q | (|beat_ev);

        if (vld_q[0]) begin
            if (last_q[0]) begin
                state_d   = IDLE;
                acc_d     = '0;
                sticky_d  = 1'b0;
                o_data_d  = beat_sum;
                o_valid_d = 1'b1;
                o_sat_d   = beat_sat;
            end else begin
                state_d  = ACC;
                acc_d    = beat_sum;
                sticky_d = beat_sat;
            end
        end
    end

    assign bus.o_data  = o_data_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_sat   = o_sat_q;
endmodule

// File: tb/tb_dot_pe_acc.sv
// Scoreboard bench for dot_pe_acc (LANES=8, DW=8, FRAC=5) with hand-computed expected results.
module tb_dot_pe_acc;
    localparam int LANES = 8;
    localparam int DW    = 8;
    localparam int LAT   = 5;

    typedef struct {
        logic [7:0] d;
        logic       s;
        int         c;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dot_pe_acc_if #(.LANES(LANES), .DW(DW)) bus ();

    dot_pe_acc #(.LANES(LANES), .DW(DW), .FRAC(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endfunction

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.o_valid) begin
            if (sb.size() == 0) begin
                check("unexpected o_valid", 32'(bus.o_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, " data"}, 32'(bus.o_data), 32'(e.d));
                check({e.name, " sat"}, 32'(bus.o_sat), 32'(e.s));
                check({e.name, " latency"}, 32'(cyc - e.c), 32'(LAT));
            end
        end
    end

    task automatic beat(input logic [63:0] data, input logic last, input string nm,
                        input logic [7:0] ed, input logic es);
        @(negedge clk);
        bus.i_data   = data;
        bus.i_valid  = 1'b1;
        bus.i_last   = last;
        bus.i_w_load = 1'b0;
        if (last) sb.push_back('{ed, es, cyc, nm});
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.i_valid  = 1'b0;
        bus.i_last   = 1'b0;
        bus.i_w_load = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic load_w(input logic [63:0] w);
        @(negedge clk);
        bus.i_valid  = 1'b0;
        bus.i_last   = 1'b0;
        bus.i_weight = w;
        bus.i_w_load = 1'b1;
        @(negedge clk);
        bus.i_w_load = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, %0d checks pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_data   = '0;
        bus.i_valid  = 1'b0;
        bus.i_last   = 1'b0;
        bus.i_weight = '0;
        bus.i_w_load = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset o_data", 32'(bus.o_data), 32'd0);
        check("reset o_valid", 32'(bus.o_valid), 32'd0);
        check("reset o_sat", 32'(bus.o_sat), 32'd0);
        rst = 1'b0;

        load_w(rep(8'h20));
        beat(rep(8'h08), 1'b1, "single", 8'h40, 1'b0);
        idle(3);
        beat(rep(8'hF8), 1'b1, "negative", 8'hC0, 1'b0);
        beat(64'h0807060504030201, 1'b1, "mixed_lanes", 8'h24, 1'b0);
        idle(2);
        beat(rep(8'h08), 1'b0, "", 8'h00, 1'b0);
        beat(rep(8'h08), 1'b1, "acc_sat", 8'h7F, 1'b1);
        beat(rep(8'h04), 1'b0, "", 8'h00, 1'b0);
        beat(rep(8'h04), 1'b0, "", 8'h00, 1'b0);
        beat(rep(8'h04), 1'b1, "three_beat", 8'h60, 1'b0);
        beat(rep(8'h04), 1'b0, "", 8'h00, 1'b0);
        idle(3);
        beat(rep(8'hFC), 1'b1, "gap", 8'h00, 1'b0);
        idle(2);
        beat(rep(8'h08), 1'b1, "b2b0", 8'h40, 1'b0);
        beat(rep(8'hF8), 1'b1, "b2b1", 8'hC0, 1'b0);
        beat(rep(8'h04), 1'b1, "b2b2", 8'h20, 1'b0);
        idle(2);

        load_w(rep(8'h7F));
        beat(rep(8'h7F), 1'b1, "prod_ovf_pos", 8'h7F, 1'b1);
        beat(rep(8'h81), 1'b1, "prod_ovf_neg", 8'h81, 1'b1);
        idle(2);

        load_w(rep(8'h10));
`ifdef DOT_PE_ACC_ROUND_EN
        beat(rep(8'h01), 1'b1, "round", 8'h08, 1'b0);
`else
        beat(rep(8'h01), 1'b1, "truncate", 8'h00, 1'b0);
`endif
        idle(2);

        load_w(rep(8'h20));
        @(negedge clk);
        bus.i_data   = rep(8'h04);
        bus.i_valid  = 1'b1;
        bus.i_last   = 1'b1;
        bus.i_weight = rep(8'h40);
        bus.i_w_load = 1'b1;
        sb.push_back('{8'h20, 1'b0, cyc, "w_same_cycle"});
        beat(rep(8'h04), 1'b1, "w_new", 8'h40, 1'b0);
        idle(10);
        check("drain before reset", 32'(sb.size()), 32'd0);

        // Partial vector: one beat parked in the accumulator, one still in the tree.
        beat(rep(8'h04), 1'b0, "", 8'h00, 1'b0);
        idle(6);
        beat(rep(8'h04), 1'b0, "", 8'h00, 1'b0);
        idle(2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid reset o_data", 32'(bus.o_data), 32'd0);
        check("mid reset o_valid", 32'(bus.o_valid), 32'd0);
        rst = 1'b0;
        beat(rep(8'h7F), 1'b1, "weights_cleared", 8'h00, 1'b0);
        load_w(rep(8'h20));
        beat(rep(8'h04), 1'b1, "post_reset", 8'h20, 1'b0);
        idle(12);
        check("drain at end", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dot_pe_acc.md
# dot_pe_acc

Parametrised successor to the single-beat 8-lane dot-product PE in the FPE vector engine. It computes saturating fixed-point dot products over LANES-element beats and accumulates consecutive beats until a last marker, so one instance handles vectors longer than its lane count. It emits one result per vector with a sticky saturation flag. It sits in the VPE array in place of the fixed 8-lane PE and is driven by the same data and weight broadcast.

## Interface
- LANES, 8: lanes per beat; power of two, 2..32.
- DW, 8: element, weight and result width; signed two's complement.
- FRAC, 5: product right-shift. Result field is product bits [FRAC+DW-1:FRAC].
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_data  in  LANES*DW  data beat; lane k is bits [k*DW+DW-1:k*DW].
- i_valid  in  1  beat valid. No backpressure: every valid beat is consumed.
- i_last  in  1  qualifies i_valid; marks the final beat of a vector.
- i_weight  in  LANES*DW  weight vector, same lane packing as i_data.
- i_w_load  in  1  load i_weight into the weight register.
- o_data  out  DW  vector result; holds until the next result.
- o_valid  out  1  one-cycle pulse per completed vector.
- o_sat  out  1  valid with o_valid; 1 if any saturation occurred anywhere in that vector.

## Operation
- Weight register: loads on i_w_load. A beat presented in the same cycle as i_w_load uses the old weights. New weights apply from the next cycle onward.
- Product stage, per lane: full 2*DW signed product, shifted by FRAC.
  - If bits [2*DW-1:FRAC+DW-1] are all equal, the result is the field.
  - Otherwise the result saturates to +(2^(DW-1)-1) if positive, or -2^(DW-1) if negative.
- Adder tree: log2(LANES) registered levels of pairwise DW-bit adds.
  - Overflow detection: both operands have the same sign and the sum has the opposite sign.
  - Positive overflow clamps to +(2^(DW-1)-1); negative overflow clamps to -(2^(DW-1)-1).
- Accumulator stage:
  - First beat of a vector loads the tree sum directly.
  - Later beats add the tree sum with the same symmetric saturation as the tree.
  - A beat with i_last completes the vector: o_data is registered from the accumulated sum, o_valid pulses, and the accumulator returns to first-beat state.
- State machine, IDLE/ACC (tracks the beat at accumulator stage):
  - IDLE -> ACC on a non-last beat.
  - ACC -> IDLE on a last beat.
  - A last beat in IDLE is a single-beat vector.
- Saturation flag: sticky per vector. It is ORed over every product, tree and accumulator saturation event of that vector's beats, then cleared when the vector completes.
- Gaps (i_valid low) between beats of a vector are allowed; state holds across them.
- Reset values: o_data=0, o_valid=0, o_sat=0, weights=0, state IDLE, accumulator 0, all stage valids 0.
- Reset mid-vector discards the partial vector; no o_valid is produced for it.

## Timing
- Fully pipelined; accepts one beat every cycle.
- Latency from a last beat sampled at edge T to o_valid high: T+2+log2(LANES). With LANES=8 this is 5 cycles.
  - 1 cycle: product register.
  - log2(LANES) cycles: tree levels.
  - 1 cycle: accumulator/output register.
- Back-to-back vectors: the beat after a last beat starts a new vector with no bubble. o_valid may pulse on consecutive cycles.

## Configuration
- DOT_PE_ACC_ROUND_EN:
  - Defined: add 2^(FRAC-1) to the full product before the shift (round half up), then saturate as above.
  - Undefined: truncate, i.e. plain shift.
  - Tree and accumulator behaviour are identical in both builds.

## Structure
- Shared package dot_pe_pkg:
  - sat_max(DW) and sat_min(DW) constant functions.
  - Saturation-event type.
  - Accumulator state enum (IDLE, ACC).
- Sub-module dot_pe_sat_add: DW-bit symmetric saturating adder with an overflow flag. It is instantiated in each tree node and in the accumulator.
- Product saturation stays inline in a generate loop.

## Test plan
All scenarios use LANES=8, DW=8, FRAC=5.
- Single beat: weights all 0x20; data all 0x08, last=1 -> 5 cycles later o_data=0x40, o_valid for 1 cycle, o_sat=0.
- Negative: data all 0xF8, weights 0x20, last=1 -> o_data=0xC0, o_sat=0.
- Accumulate with saturation: two beats of data 0x08, weights 0x20, last on the second beat -> o_data=0x7F, o_sat=1, exactly one o_valid.
- Product overflow: data all 0x7F, weights 0x7F -> o_data=0x7F, o_sat=1. Same with data 0x81 -> o_data=0x81, o_sat=1.
- Rounding: data all 0x01, weights 0x10:
  - With DOT_PE_ACC_ROUND_EN -> o_data=0x08.
  - Without it -> o_data=0x00.
- Weight load, back-to-back and reset:
  - i_w_load with new weights in the same cycle as a beat -> that beat uses the old weights.
  - Back-to-back single-beat vectors -> o_valid on consecutive cycles.
  - rst asserted mid-vector -> no o_valid; the next vector's result is uncontaminated by the discarded beats.
